sample_packer: RTL and testbench
================================

Name: sample_packer

Overview:
- Parametrised acquisition core for the fast clock domain of the logic analyser.
- Samples an NUM_CH-bit probe bus at a programmable rate and keeps only the enabled channels.
- Packs the enabled channel bits densely, LSB first, into OUT_W-bit words for the sample FIFO write port.
- Generalises the fixed 16-channel sampler with arbitrary channel count and word width, config latching at start, end-of-capture flush of partial words, and an explicit stall state.

Parameters:
- NUM_CH, 16, probe channel count; 1 <= NUM_CH <= OUT_W.
- OUT_W, 16, output word width in bits.
- DIV_W, 8, clock divisor width.

Ports:
- clk  input  1  sampling clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- probe  input  NUM_CH  raw probe inputs, already synchronised to clk.
- acq_enable  input  1  run request, level, synchronous to clk.
- clock_divisor  input  DIV_W  sample period minus one.
- channel_enable  input  NUM_CH  per-channel enable mask.
- overflow  input  1  FIFO overflow indication, synchronous to clk.
- out_data  output  OUT_W  packed sample word.
- out_valid  output  1  single-cycle write strobe for out_data.
- stalled  output  1  sticky: capture halted because of overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; out_data=0; out_valid=0; stalled=0; fill=0; div_cnt=0; accumulator=0; latched config=0.
- Input register: probe_q is loaded from probe every cycle.
- States: IDLE, RUN, FLUSH, STALL.
- IDLE:
  - When acq_enable=1, latch channel_enable into en_l and clock_divisor into div_l, clear fill, div_cnt and stalled, then go to RUN.
  - Config changes while in RUN are ignored.
- RUN, sample tick:
  - tick = (div_cnt==0).
  - On tick, div_cnt is reloaded with div_l; otherwise div_cnt decrements.
  - The tick period is therefore div_l+1 cycles. The first tick is the first RUN cycle.
- RUN, compaction:
  - k = popcount(en_l), range 0..NUM_CH.
  - Enabled bit i of probe_q maps to compacted position popcount(en_l[i-1:0]).
  - Disabled channels are dropped.
- RUN, accumulation:
  - On tick, the compacted bits are appended above the current fill bits of the accumulator (width OUT_W+NUM_CH).
  - If fill+k >= OUT_W, the next cycle has out_data = low OUT_W bits and out_valid=1. The remainder is shifted down, so fill becomes fill+k-OUT_W.
  - Otherwise fill becomes fill+k.
  - Because NUM_CH <= OUT_W, there is at most one word per tick and out_valid is never high two cycles running unless div_l=0.
- Latency: probe at cycle t appears in out_data no earlier than t+2.
- Empty mask (en_l=0): k=0, no words are ever produced; the state machine still runs and responds to acq_enable and overflow.
- RUN to FLUSH: acq_enable=0 with no overflow goes to FLUSH. A tick in that same cycle is discarded.
- FLUSH:
  - If fill>0, emit one word next cycle: out_data = accumulator bits [fill-1:0], upper bits zero, out_valid=1.
  - Then fill=0 and go to IDLE. If fill=0, go straight to IDLE with no strobe.
- STALL:
  - overflow=1 in RUN or FLUSH sets stalled=1 the next cycle and goes to STALL.
  - overflow has priority over acq_enable=0, a tick, and a pending word, which is dropped.
  - STALL keeps out_valid=0 and holds stalled=1.
  - It returns to IDLE when acq_enable=0; stalled stays 1 until the next IDLE to RUN transition.
  - overflow in IDLE is ignored.
- Restart: acq_enable back to 1 in the same cycle FLUSH completes is honoured next cycle from IDLE.
- Reset mid-operation: an asynchronous reset discards partial data; there is no flush.

Test Plan:
- Full mask, no division: NUM_CH=16, OUT_W=16, en=0xFFFF, div=0, probe counting 0,1,2.
  - Required: out_valid high every cycle from 2 cycles after start.
  - Required: out_data sequence 0,1,2, equal to probe delayed by 2.
- Nibble packing: en=0x000F, div=0, probe low nibble sequence 1,2,3,4,5,6,7,8.
  - Required: words 0x4321, then 0x8765, one strobe every 4 cycles.
- Divisor and sparse mask: div=3, en=0x0101, probe=0x0100 constant.
  - Required: tick every 4 cycles, 2 bits per tick.
  - Required: one word 0xAAAA after 8 ticks (32 cycles).
- Flush: en=0x000F, three ticks of 0xA, 0xB, 0xC, then acq_enable=0.
  - Required: a single strobe with out_data=0x0CBA, then IDLE.
- Overflow: assert overflow 1 cycle mid-RUN.
  - Required: stalled=1 next cycle, no further out_valid, stalled held through acq_enable=0.
  - Required: stalled cleared on next start.
- Mask change and empty mask:
  - Change channel_enable mid-RUN. Required: packing is unaffected.
  - Start with en=0. Required: zero strobes over 100 cycles.
  - Assert rst_n=0 mid-run. Required: all outputs 0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/sample_packer.sv
// Logic-analyser acquisition core: samples the probe bus at a programmable rate,
// drops disabled channels and packs the rest LSB-first into OUT_W-bit words.
module sample_packer #(
  parameter int NUM_CH = 16,
  parameter int OUT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] probe,
  input  logic              acq_enable,
  input  logic [DIV_W-1:0]  clock_divisor,
  input  logic [NUM_CH-1:0] channel_enable,
  input  logic              overflow,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              stalled
);

  localparam int ACC_W  = OUT_W + NUM_CH;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ONE_F   = FILL_W'(1);
  localparam logic [DIV_W-1:0]  ONE_D   = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, STALL} state_e;

  state_e              state_q;
  logic [NUM_CH-1:0]   probe_q;
  logic [NUM_CH-1:0]   en_l_q;
  logic [DIV_W-1:0]    div_l_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [FILL_W-1:0]   fill_q;
  logic [ACC_W-1:0]    acc_q;
  logic [OUT_W-1:0]    out_data_q;
  logic                out_valid_q;
  logic                stalled_q;

  logic                tick;
  logic [ACC_W-1:0]    merged;
  logic [FILL_W-1:0]   pos;
  logic                word_ready;
  logic [OUT_W-1:0]    flush_word;

  assign tick       = (div_cnt_q == '0);
  assign flush_word = acc_q[OUT_W-1:0] & ~({OUT_W{1'b1}} << fill_q);

  // Append every enabled channel above the current fill level; pos ends at fill+k.
  always_comb begin
    merged = acc_q;
    pos    = fill_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_l_q[i]) begin
        // NOTE: blocking assignments here form a running chain within one evaluation;
        // each enabled channel sees the position left by the previous one.
        merged = merged | (ACC_W'(probe_q[i]) << pos);
        pos    = pos + ONE_F;
      end
    end
    word_ready = (pos >= OUT_W_F);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_q <= '0;
    end else begin
      probe_q <= probe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_l_q      <= '0;
      div_l_q     <= '0;
      div_cnt_q   <= '0;
      fill_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acq_enable) begin
            en_l_q    <= channel_enable;
            div_l_q   <= clock_divisor;
            div_cnt_q <= '0;
            fill_q    <= '0;
            acc_q     <= '0;
            stalled_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          // Overflow wins over stop and over any word completing this cycle.
          if (overflow) begin
            stalled_q <= 1'b1;
            state_q   <= STALL;
          end else if (!acq_enable) begin
            state_q <= FLUSH;
          end else if (tick) begin
            div_cnt_q <= div_l_q;
            if (word_ready) begin
              out_data_q  <= merged[OUT_W-1:0];
              out_valid_q <= 1'b1;
              acc_q       <= merged >> OUT_W;
              fill_q      <= pos - OUT_W_F;
            end else begin
              acc_q  <= merged;
              fill_q <= pos;
            end
          end else begin
            div_cnt_q <= div_cnt_q - ONE_D;
          end
        end
        FLUSH: begin
          if (overflow) begin
            stalled_q <= 1'b1;
            state_q   <= STALL;
          end else begin
            if (fill_q != '0) begin
              out_data_q  <= flush_word;
              out_valid_q <= 1'b1;
            end
            fill_q  <= '0;
            acc_q   <= '0;
            state_q <= IDLE;
          end
        end
        STALL: begin
          if (!acq_enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed self-checking bench for sample_packer (NUM_CH=16, OUT_W=16, DIV_W=8).
module tb_sample_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] probe;
  logic        acq_enable;
  logic [7:0]  clock_divisor;
  logic [15:0] channel_enable;
  logic        overflow;
  logic [15:0] out_data;
  logic        out_valid;
  logic        stalled;

  int n_cmp = 0;
  int n_err = 0;

  sample_packer #(.NUM_CH(16), .OUT_W(16), .DIV_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .probe          (probe),
    .acq_enable     (acq_enable),
    .clock_divisor  (clock_divisor),
    .channel_enable (channel_enable),
    .overflow       (overflow),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .stalled        (stalled)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    acq_enable     = 1'b0;
    overflow       = 1'b0;
    probe          = '0;
    clock_divisor  = '0;
    channel_enable = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (stalled !== 1'b0)   begin n_err++; $display("FAIL reset_stalled: got %b want 0", stalled); end
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_full_mask();
    channel_enable = 16'hFFFF;
    clock_divisor  = 8'd0;
    probe          = 16'd0;
    acq_enable     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_cmp++;
      if (out_valid !== (c >= 2)) begin n_err++; $display("FAIL full_valid c=%0d: got %b want %b", c, out_valid, (c >= 2)); end
      if (c >= 2) begin
        n_cmp++;
        if (out_data !== 16'(c - 2)) begin n_err++; $display("FAIL full_data c=%0d: got %h want %h", c, out_data, 16'(c - 2)); end
      end
      probe = 16'(c);
    end
    acq_enable = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_stop_tick: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_empty_flush: got %b want 0", out_valid); end
    step();
  endtask

  task automatic test_nibble();
    channel_enable = 16'h000F;
    clock_divisor  = 8'd0;
    probe          = 16'd1;
    acq_enable     = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      n_cmp++;
      if (out_valid !== (c == 5 || c == 9)) begin n_err++; $display("FAIL nib_valid c=%0d: got %b", c, out_valid); end
      if (c == 5) begin
        n_cmp++; if (out_data !== 16'h4321) begin n_err++; $display("FAIL nib_word0: got %h want 4321", out_data); end
      end
      if (c == 9) begin
        n_cmp++; if (out_data !== 16'h8765) begin n_err++; $display("FAIL nib_word1: got %h want 8765", out_data); end
      end
      if (c < 8) probe = 16'(c + 1);
    end
    acq_enable = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nib_flush: got %b want 0", out_valid); end
    step();
  endtask

  // Also changes mask and divisor mid-run; the latched config must be kept.
  task automatic test_divisor_sparse();
    int strobes;
    strobes        = 0;
    channel_enable = 16'h0101;
    clock_divisor  = 8'd3;
    probe          = 16'h0100;
    acq_enable     = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      step();
      if (c == 3) begin
        channel_enable = 16'hFFFF;
        clock_divisor  = 8'd0;
      end
      if (out_valid === 1'b1) strobes++;
      if (c == 30) begin
        n_cmp++; if (out_valid !== 1'b1)   begin n_err++; $display("FAIL div_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 16'hAAAA) begin n_err++; $display("FAIL div_word: got %h want aaaa", out_data); end
      end
    end
    n_cmp++; if (strobes !== 1) begin n_err++; $display("FAIL div_strobe_count: got %0d want 1", strobes); end
    acq_enable = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b1)    begin n_err++; $display("FAIL div_flush_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0002) begin n_err++; $display("FAIL div_flush_word: got %h want 0002", out_data); end
    step();
    n_cmp++; if (out_valid !== 1'b0)    begin n_err++; $display("FAIL div_after_flush: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_restart();
    channel_enable = 16'h000F;
    clock_divisor  = 8'd0;
    probe          = 16'h000A;
    acq_enable     = 1'b1;
    step();
    probe = 16'h000B;
    step();
    probe = 16'h000C;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_pre: got %b want 0", out_valid); end
    acq_enable = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_enter: got %b want 0", out_valid); end
    acq_enable = 1'b1;
    probe      = 16'h0005;
    step();
    n_cmp++; if (out_valid !== 1'b1)    begin n_err++; $display("FAIL flush_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0CBA) begin n_err++; $display("FAIL flush_word: got %h want 0cba", out_data); end
    for (int c = 7; c <= 11; c++) begin
      step();
      n_cmp++;
      if (out_valid !== (c == 11)) begin n_err++; $display("FAIL restart_valid c=%0d: got %b", c, out_valid); end
    end
    n_cmp++; if (out_data !== 16'h5555) begin n_err++; $display("FAIL restart_word: got %h want 5555", out_data); end
    acq_enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_overflow();
    channel_enable = 16'h000F;
    clock_divisor  = 8'd0;
    probe          = 16'h0003;
    overflow       = 1'b1;
    step();
    overflow = 1'b0;
    n_cmp++; if (stalled !== 1'b0) begin n_err++; $display("FAIL ovf_idle_ignored: got %b want 0", stalled); end
    acq_enable = 1'b1;
    step();
    step();
    step();
    n_cmp++; if (stalled !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b want 0", stalled); end
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    n_cmp++; if (stalled !== 1'b1) begin n_err++; $display("FAIL ovf_stalled: got %b want 1", stalled); end
    for (int c = 5; c <= 7; c++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || stalled !== 1'b1) begin
        n_err++; $display("FAIL ovf_hold c=%0d: valid %b stalled %b want 0/1", c, out_valid, stalled);
      end
    end
    acq_enable = 1'b0;
    step();
    step();
    n_cmp++; if (stalled !== 1'b1)   begin n_err++; $display("FAIL ovf_idle_sticky: got %b want 1", stalled); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_idle_valid: got %b want 0", out_valid); end
    acq_enable = 1'b1;
    step();
    n_cmp++; if (stalled !== 1'b0) begin n_err++; $display("FAIL ovf_restart_clear: got %b want 0", stalled); end
    repeat (4) step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h3333) begin
      n_err++; $display("FAIL ovf_restart_word: valid %b data %h want 1/3333", out_valid, out_data);
    end
    acq_enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_empty_mask();
    int strobes;
    strobes        = 0;
    channel_enable = 16'h0000;
    clock_divisor  = 8'd0;
    acq_enable     = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      probe = 16'(c * 37);
      step();
      if (out_valid === 1'b1) strobes++;
    end
    n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL empty_strobes: got %0d want 0", strobes); end
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    n_cmp++; if (stalled !== 1'b1) begin n_err++; $display("FAIL empty_ovf: got %b want 1", stalled); end
    acq_enable = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_run();
    channel_enable = 16'hFFFF;
    clock_divisor  = 8'd0;
    probe          = 16'hFFFF;
    acq_enable     = 1'b1;
    repeat (4) step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
      n_err++; $display("FAIL rst_pre: valid %b data %h want 1/ffff", out_valid, out_data);
    end
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    n_cmp++; if (stalled !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %b want 1", stalled); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rst_async_data: got %h want 0000", out_data); end
    n_cmp++; if (stalled !== 1'b0)   begin n_err++; $display("FAIL rst_async_stalled: got %b want 0", stalled); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    acq_enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_after: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_nibble();
    test_divisor_sparse();
    test_flush_restart();
    test_overflow();
    test_empty_mask();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
